uart_rx_fsm: RTL
================

UART_RX_FSM -- requirements
Module: uart_rx_fsm

Interface
REQ-001 Parameter CLKS_PER_BIT, default 5208: clk cycles per bit period (50 MHz / 9600 baud); legal range 4..65535.
REQ-002 Parameter PARITY_EVEN, default 1: 1 selects even parity, 0 selects odd parity.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 rx_i  input  1  serial line, asynchronous to clk, idle high.
REQ-006 rx_data  output  8  last received data byte.
REQ-007 rx_done  output  1  one-cycle pulse when a frame completes.
REQ-008 parity_err  output  1  parity result of the last frame, valid with rx_done.
REQ-009 frame_err  output  1  stop-bit result of the last frame, valid with rx_done.
REQ-010 busy  output  1  high in every state except IDLE.

Function
REQ-011 The frame format SHALL be 1 start bit (0), 8 data bits LSB first, 1 parity bit and 1 stop bit (1).
REQ-012 rx_i SHALL pass through a 2-flop synchronizer; all FSM logic SHALL use only the synchronized value rxs.
REQ-013 A 16-bit bit-timer SHALL count clk cycles; a sample strobe fires when the timer reaches its terminal count, and the timer then reloads to 0.
REQ-014 A 4-bit bit counter SHALL count received data bits from 0 to 8.
REQ-015 States SHALL be IDLE, START, DATA, PARITY, STOP and BREAK.
REQ-016 IDLE: timer and bit counter held at 0; on rxs == 0, go to START.
REQ-017 START: terminal count is CLKS_PER_BIT/2-1 (integer division), which gives a mid-bit sample.
- Sample rxs == 0: go to DATA.
- Sample rxs == 1: false start; go to IDLE with no rx_done and no flag change.
REQ-018 DATA: terminal count is CLKS_PER_BIT-1.
- Each strobe shifts rxs into bit 7 of the shift register (right shift) and increments the bit counter.
- When the counter reaches 8 (after the 8th shift), go to PARITY.
REQ-019 PARITY: on the strobe, compute the error in a registered value perr.
- PARITY_EVEN=1: perr = rxs XOR (XOR-reduction of the shift register).
- PARITY_EVEN=0: perr is the inverse of that value.
- Then go to STOP.
REQ-020 STOP: on the strobe, in one clk edge:
- rx_data <= shift register;
- parity_err <= perr;
- frame_err <= (rxs == 0);
- rx_done <= 1.
- Next state is IDLE if rxs == 1, otherwise BREAK.
REQ-021 BREAK: wait until rxs == 1, then go to IDLE; no start detection is allowed while in BREAK.
REQ-022 rx_done SHALL be high for exactly one cycle per completed frame and SHALL return to 0 on the next clk edge.
REQ-023 rx_data, parity_err and frame_err SHALL hold their values until the next completed frame; a false start or a frame aborted by reset SHALL NOT change them.
REQ-024 A frame whose start edge arrives in the cycle after a STOP-to-IDLE transition SHALL be received normally (back-to-back frames, no idle gap required).
REQ-025 Latency: rx_done SHALL assert 2 + CLKS_PER_BIT/2 + 10*CLKS_PER_BIT cycles (±1) after rx_i falls at the start bit.
REQ-026 Illegal state encodings SHALL go to IDLE on the next clk edge.

Reset
REQ-027 While rst is high, the following SHALL be forced asynchronously:
- state IDLE;
- timer 0 and bit counter 0;
- shift register 0x00;
- both synchronizer flops 1;
- rx_data 0x00, rx_done 0, parity_err 0, frame_err 0, busy 0.
REQ-028 Reset asserted mid-frame SHALL abort the frame with no rx_done; after release, the block waits for a new falling edge.

Verification (CLKS_PER_BIT=16, PARITY_EVEN=1)
REQ-029 Frame 0x55, parity 0, stop 1 -> single rx_done pulse, rx_data=0x55, parity_err=0, frame_err=0, busy returns to 0.
REQ-030 Frame 0xA7, parity 0 (wrong; correct value is 1) -> rx_done pulse, rx_data=0xA7, parity_err=1, frame_err=0.
REQ-031 Frame 0x3C with stop bit 0, line then held low 40 cycles -> rx_done with frame_err=1; busy stays 1 in BREAK until the line goes high; no second frame is detected.
REQ-032 Low glitch of 4 cycles on an idle line -> returns to IDLE, no rx_done, outputs unchanged.
REQ-033 Reset pulse during data bit 4 of frame 0xFF -> no rx_done, rx_data stays at its prior value; the following frame 0x81 is received correctly.
REQ-034 Two back-to-back frames 0x01 then 0xFE with no idle gap -> two rx_done pulses with the correct data and no error flags.

Source files
------------

// File: rtl/uart_rx_fsm.sv
// UART receiver: 8 data bits LSB first, one parity bit, one stop bit.
// Samples mid-bit from a synchronized copy of the serial line.
module uart_rx_fsm #(
    parameter int CLKS_PER_BIT = 5208,
    parameter bit PARITY_EVEN  = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_i,
    output logic [7:0] rx_data,
    output logic       rx_done,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);

    localparam logic [15:0] FULL_TC = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_TC = 16'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } state_t;

    state_t      state;
    logic        sync1;
    logic        rxs;
    logic [15:0] timer;
    logic [3:0]  bit_cnt;
    logic [7:0]  shift_reg;
    logic        perr;
    logic        strobe;

    // Synchronizer flops reset high so reset never looks like a start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
        end else begin
            sync1 <= rx_i;
            rxs   <= sync1;
        end
    end

    // The start bit uses a half-period terminal count to land on mid-bit.
    always_comb begin
        strobe = 1'b0;
        if (state == START)
            strobe = (timer == HALF_TC);
        else
            strobe = (timer == FULL_TC);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            timer      <= 16'd0;
            bit_cnt    <= 4'd0;
            shift_reg  <= 8'h00;
            perr       <= 1'b0;
            rx_data    <= 8'h00;
            rx_done    <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            rx_done <= 1'b0;
            case (state)
                IDLE: begin
                    timer   <= 16'd0;
                    bit_cnt <= 4'd0;
                    if (!rxs) begin
                        state <= START;
                        busy  <= 1'b1;
                    end
                end

                START: begin
                    if (strobe) begin
                        timer <= 16'd0;
                        if (!rxs) begin
                            state <= DATA;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end

                DATA: begin
                    if (strobe) begin
                        timer     <= 16'd0;
                        shift_reg <= {rxs, shift_reg[7:1]};
                        bit_cnt   <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7)
                            state <= PARITY;
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end

                PARITY: begin
                    if (strobe) begin
                        timer <= 16'd0;
                        perr  <= rxs ^ (^shift_reg) ^ !PARITY_EVEN;
                        state <= STOP;
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end

                // A low stop bit means a break: hold off start detection until the line recovers.
                STOP: begin
                    if (strobe) begin
                        timer      <= 16'd0;
                        rx_data    <= shift_reg;
                        parity_err <= perr;
                        frame_err  <= !rxs;
                        rx_done    <= 1'b1;
                        if (rxs) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= BREAK;
                        end
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end

                BREAK: begin
                    timer   <= 16'd0;
                    bit_cnt <= 4'd0;
                    if (rxs) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end

                default: begin
                    state   <= IDLE;
                    timer   <= 16'd0;
                    bit_cnt <= 4'd0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
